cpu_mem_arbiter: RTL and testbench

//  Shares one 64-bit single-ported memory port between the instruction fetch bus (cpu_ibus_if.slave)
//  and the load/store bus (cpu_dbus_if.slave). Sits between the core and the memory/cache wrapper.

---
 rtl/cpu_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cpu_mem_arbiter
// Purpose : Shares one 64-bit memory port between instruction and data buses,
//           one transaction at a time, with bounded ibus starvation.
// Rev     : 1.0
// ============================================================================
module cpu_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction fetch bus
  input  logic        ibus_ena,
  input  logic [63:0] ibus_addr,
  output logic        ibus_valid1,
  output logic        ibus_valid2,
  output logic [31:0] ibus_rdata1,
  output logic [31:0] ibus_rdata2,
  // load/store bus
  input  logic        dbus_ena,
  input  logic [7:0]  dbus_wea,
  input  logic [2:0]  dbus_rlen,
  input  logic [63:0] dbus_addr,
  input  logic [63:0] dbus_wdata,
  output logic [63:0] dbus_rdata,
  output logic        dbus_stall,
  // memory port
  output logic        mem_req,
  output logic [7:0]  mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_REQ  = 3'd1,
    D_WAIT = 3'd2,
    I_REQ  = 3'd3,
    I_WAIT = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [63:0]     r_addr, r_wdata, r_dbus_rdata;
  logic [7:0]      r_we;
  logic [2:0]      r_rlen;
  logic [SW-1:0]   r_starve;
  logic [31:0]     r_rdata1, r_rdata2;

  logic            w_sel_d, w_sel_i;
  logic            w_d_done, w_d_rd_done, w_i_deliver;
  logic [2:0]      w_mask_bytes;
  logic [63:0]     w_shifted, w_mask, w_aligned;
  logic [31:0]     w_rdata1;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_d     = 1'b0;
    w_sel_i     = 1'b0;
    mem_req     = 1'b0;
    case (r_state)
      IDLE: begin
        // dbus wins unless ibus has already waited out its starvation budget
        if (dbus_ena && !(ibus_ena && r_starve == STARVE_MAX)) begin
          w_sel_d     = 1'b1;
          w_state_nxt = D_REQ;
        end else if (ibus_ena) begin
          w_sel_i     = 1'b1;
          w_state_nxt = I_REQ;
        end
      end
      D_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) w_state_nxt = D_WAIT;
      end
      D_WAIT: if (mem_rvalid) w_state_nxt = IDLE;
      I_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) w_state_nxt = I_WAIT;
      end
      I_WAIT: if (mem_rvalid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // read alignment: shift the addressed byte to bit 0, keep rlen+1 bytes
  assign w_mask_bytes = 3'd7 - r_rlen;
  assign w_shifted    = mem_rdata >> {r_addr[2:0], 3'b000};
  assign w_mask       = {64{1'b1}} >> {w_mask_bytes, 3'b000};
  assign w_aligned    = w_shifted & w_mask;

  assign w_d_done    = (r_state == D_WAIT) && mem_rvalid;
  assign w_d_rd_done = w_d_done && (r_we == 8'h00);
  assign w_i_deliver = (r_state == I_WAIT) && mem_rvalid && ibus_ena && (ibus_addr == r_addr);
  assign w_rdata1    = r_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];

  assign dbus_stall  = dbus_ena && !w_d_done;
  assign dbus_rdata  = w_d_rd_done ? w_aligned : r_dbus_rdata;
  assign ibus_valid1 = w_i_deliver;
  assign ibus_valid2 = w_i_deliver && !r_addr[2];
  assign ibus_rdata1 = w_i_deliver ? w_rdata1 : r_rdata1;
  assign ibus_rdata2 = (w_i_deliver && !r_addr[2]) ? mem_rdata[63:32] : r_rdata2;

  assign mem_addr  = {r_addr[63:3], 3'b000};
  assign mem_we    = r_we;
  assign mem_wdata = r_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_we         <= '0;
      r_wdata      <= '0;
      r_rlen       <= '0;
      r_starve     <= '0;
      r_dbus_rdata <= '0;
      r_rdata1     <= '0;
      r_rdata2     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sel_d) begin
        r_addr  <= dbus_addr;
        r_we    <= dbus_wea;
        r_wdata <= dbus_wdata;
        r_rlen  <= dbus_rlen;
      end else if (w_sel_i) begin
        r_addr  <= ibus_addr;
        r_we    <= '0;
        r_wdata <= '0;
      end
      if (w_sel_i || (r_state == IDLE && !ibus_ena)) begin
        r_starve <= '0;
      end else if (w_sel_d && ibus_ena && r_starve != STARVE_MAX) begin
        r_starve <= r_starve + 1'b1;
      end
      if (w_d_rd_done) r_dbus_rdata <= w_aligned;
      if (w_i_deliver) begin
        r_rdata1 <= w_rdata1;
        if (!r_addr[2]) r_rdata2 <= mem_rdata[63:32];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_mem_arbiter
// Purpose : Scoreboard bench for cpu_mem_arbiter with a randomized memory model.
// Rev     : 1.0
// ============================================================================
module tb_cpu_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ibus_ena, ibus_valid1, ibus_valid2;
  logic [63:0] ibus_addr;
  logic [31:0] ibus_rdata1, ibus_rdata2;
  logic        dbus_ena, dbus_stall;
  logic [7:0]  dbus_wea;
  logic [2:0]  dbus_rlen;
  logic [63:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [7:0]  mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .ibus_ena(ibus_ena), .ibus_addr(ibus_addr), .ibus_valid1(ibus_valid1),
    .ibus_valid2(ibus_valid2), .ibus_rdata1(ibus_rdata1), .ibus_rdata2(ibus_rdata2),
    .dbus_ena(dbus_ena), .dbus_wea(dbus_wea), .dbus_rlen(dbus_rlen),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata),
    .dbus_stall(dbus_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct { bit wr; logic [63:0] data; } d_exp_t;
  typedef struct { logic [31:0] r1; logic [31:0] r2; bit v2; } i_exp_t;

  d_exp_t      d_exp[$];
  i_exp_t      i_exp[$];
  logic [63:0] grant_log[$];
  logic [63:0] ref_mem[logic [63:0]];
  logic [63:0] phy_mem[logic [63:0]];
  logic [63:0] last_rd = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          gnt_fix = 0;
  int          rv_fix = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DE_F00D, a[31:0] + 32'h1357_9BDF};
  endfunction

  function automatic logic [63:0] model_word(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [63:0] phy_word(input logic [63:0] a);
    return phy_mem.exists(a) ? phy_mem[a] : init_word(a);
  endfunction

  function automatic logic [63:0] rand_iaddr();
    return 64'h8000 + 64'(4 * $urandom_range(0, 63));
  endfunction

  // expected result computed byte-by-byte from the reference memory
  task automatic dbus_issue(input bit wr, input logic [63:0] addr, input logic [2:0] rlen,
                            input logic [7:0] wea, input logic [63:0] wdata);
    logic [63:0] al, w, e;
    int off;
    al  = {addr[63:3], 3'b000};
    off = int'(addr[2:0]);
    w   = model_word(al);
    e   = '0;
    if (wr) begin
      for (int i = 0; i < 8; i++) if (wea[i]) w[8*i +: 8] = wdata[8*i +: 8];
      ref_mem[al] = w;
      d_exp.push_back('{wr: 1'b1, data: 64'h0});
    end else begin
      for (int i = 0; i <= int'(rlen); i++) e[8*i +: 8] = w[8*(off+i) +: 8];
      d_exp.push_back('{wr: 1'b0, data: e});
    end
    dbus_ena   = 1'b1;
    dbus_addr  = addr;
    dbus_rlen  = rlen;
    dbus_wea   = wr ? wea : 8'h00;
    dbus_wdata = wdata;
  endtask

  task automatic dbus_wait(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbus_stall && n < 200);
    if (dbus_stall) chk("dbus_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic ibus_issue(input logic [63:0] a);
    logic [63:0] w;
    w = model_word({a[63:3], 3'b000});
    i_exp.push_back('{r1: a[2] ? w[63:32] : w[31:0], r2: w[63:32], v2: !a[2]});
    ibus_ena  = 1'b1;
    ibus_addr = a;
  endtask

  task automatic ibus_wait(input int redirect_pct);
    int n;
    bit redone;
    n = 0;
    redone = 1'b0;
    forever begin
      @(negedge clk);
      if (ibus_valid1) break;
      n++;
      if (n > 200) begin
        chk("ibus_timeout", 1, 0);
        break;
      end
      if (!redone && $urandom_range(0, 99) < redirect_pct) begin
        @(posedge clk); #1;
        i_exp.delete(i_exp.size() - 1);
        ibus_issue(rand_iaddr());
        redone = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [63:0] a, input logic [63:0] w);
    ref_mem[a] = w;
    phy_mem[a] = w;
  endtask

  // memory port model: programmable grant and completion delays
  initial begin : mem_model
    int gnt_cnt, rv_cnt;
    bit pend, in_req;
    logic [63:0] h_addr, h_wdata, pend_data, w;
    logic [7:0]  h_we;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    pend = 1'b0; in_req = 1'b0; gnt_cnt = 0; rv_cnt = 0;
    h_addr = '0; h_wdata = '0; h_we = '0; pend_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!resetn) begin
        pend = 1'b0;
        in_req = 1'b0;
      end else if (pend) begin
        chk("req_dropped_after_gnt", mem_req, 0);
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = pend_data;
          pend = 1'b0;
        end else rv_cnt--;
      end else if (mem_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
          gnt_cnt = (gnt_fix >= 0) ? gnt_fix : int'($urandom_range(0, 3));
        end else begin
          chk("req_addr_stable", mem_addr, h_addr);
          chk("req_we_stable", mem_we, h_we);
          chk("req_wdata_stable", mem_wdata, h_wdata);
        end
        if (gnt_cnt == 0) begin
          mem_gnt = 1'b1;
          in_req = 1'b0;
          grant_log.push_back(mem_addr);
          chk("mem_addr_aligned", mem_addr[2:0], 0);
          w = phy_word(mem_addr);
          if (mem_we != 8'h00) begin
            for (int i = 0; i < 8; i++) if (mem_we[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            phy_mem[mem_addr] = w;
          end
          pend_data = w;
          pend = 1'b1;
          rv_cnt = (rv_fix >= 0) ? rv_fix : int'($urandom_range(0, 3));
        end else gnt_cnt--;
      end
    end
  end

  initial begin : monitor
    d_exp_t de;
    i_exp_t ie;
    logic [63:0] want;
    forever begin
      @(negedge clk);
      if (resetn && dbus_ena && !dbus_stall) begin
        if (d_exp.size() == 0) chk("dbus_unexpected_done", 1, 0);
        else begin
          de = d_exp.pop_front();
          want = de.wr ? last_rd : de.data;
          if (!de.wr) last_rd = de.data;
          chk("dbus_rdata", dbus_rdata, want);
        end
      end
      if (ibus_valid1) begin
        if (i_exp.size() == 0) chk("ibus_unexpected_valid", 1, 0);
        else begin
          ie = i_exp.pop_front();
          chk("ibus_rdata1", ibus_rdata1, ie.r1);
          chk("ibus_valid2", ibus_valid2, ie.v2);
          if (ie.v2) chk("ibus_rdata2", ibus_rdata2, ie.r2);
        end
      end else if (ibus_valid2) chk("ibus_valid2_alone", 1, 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int n;
    resetn = 1'b0; ibus_ena = 1'b0; ibus_addr = '0;
    dbus_ena = 1'b1; dbus_wea = '0; dbus_rlen = '0; dbus_addr = '0; dbus_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_valid1", ibus_valid1, 0);
    chk("rst_valid2", ibus_valid2, 0);
    chk("rst_rdata1", ibus_rdata1, 0);
    chk("rst_rdata2", ibus_rdata2, 0);
    chk("rst_dbus_rdata", dbus_rdata, 0);
    chk("rst_stall_ena1", dbus_stall, 1);
    dbus_ena = 1'b0;
    #1 chk("rst_stall_ena0", dbus_stall, 0);
    @(posedge clk); #2;
    resetn = 1'b1;

    // sub-word read alignment and zero-wait latency
    preload(64'h1000, 64'h8877665544332211);
    @(posedge clk); #1;
    dbus_issue(1'b0, 64'h1003, 3'd1, 8'h00, 64'h0);
    dbus_wait(n);
    chk("d_latency", n, 3);
    dbus_ena = 1'b0;

    // full-word then upper-half fetch
    preload(64'h2000, 64'hBBBBBBBB_AAAAAAAA);
    ibus_issue(64'h2000);
    ibus_wait(0);
    ibus_issue(64'h2004);
    ibus_wait(0);
    ibus_ena = 1'b0;

    // grant held off for 5 cycles, then read back the merged write
    gnt_fix = 5;
    dbus_issue(1'b1, 64'h1000_0020, 3'd0, 8'hF0, 64'h0123_4567_89AB_CDEF);
    dbus_wait(n);
    chk("d_latency_gnt5", n, 8);
    gnt_fix = 0;
    dbus_issue(1'b0, 64'h1000_0020, 3'd7, 8'h00, 64'h0);
    dbus_wait(n);
    dbus_ena = 1'b0;

    // fetch redirected while the memory access is in flight
    rv_fix = 3;
    ibus_issue(64'h3000);
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_gnt && n < 50);
    chk("redirect_gnt_seen", mem_gnt, 1);
    @(posedge clk); #1;
    i_exp.delete(i_exp.size() - 1);
    ibus_issue(64'h4000);
    ibus_wait(0);
    chk("redirect_refetch", grant_log[grant_log.size() - 1], 64'h4000);
    ibus_ena = 1'b0;

    // reset while a dbus read waits for completion
    rv_fix = 4;
    dbus_issue(1'b0, 64'h1000_0020, 3'd7, 8'h00, 64'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_gnt && n < 50);
    chk("rstmid_gnt_seen", mem_gnt, 1);
    @(posedge clk); #2;
    resetn = 1'b0;
    @(negedge clk);
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_stall", dbus_stall, 1);
    chk("rstmid_dbus_rdata", dbus_rdata, 0);
    d_exp.delete();
    last_rd = '0;
    rv_fix = 0;
    @(posedge clk); #2;
    resetn = 1'b1;
    dbus_issue(1'b0, 64'h1000_0020, 3'd7, 8'h00, 64'h0);
    dbus_wait(n);
    chk("rstmid_reissue", grant_log[grant_log.size() - 1], 64'h1000_0020);
    dbus_ena = 1'b0;

    // both buses requesting continuously: starvation bound
    grant_log.delete();
    fork
      begin
        int nd;
        for (int k = 0; k < 10; k++) begin
          dbus_issue(1'b0, 64'h1000_0000 + 64'(8 * k), 3'd7, 8'h00, 64'h0);
          dbus_wait(nd);
        end
        dbus_ena = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          ibus_issue(64'h5000 + 64'(4 * k));
          ibus_wait(0);
        end
        ibus_ena = 1'b0;
      end
    join
    chk("starve_grant_count", grant_log.size() >= 10, 1);
    for (int k = 0; k < 10 && k < grant_log.size(); k++)
      chk($sformatf("grant_order_%0d_is_dbus", k), grant_log[k] >= 64'h1000_0000, (k % 5) != 4);

    // randomized concurrent traffic
    gnt_fix = -1;
    rv_fix = -1;
    fork
      begin
        int nd, sz, bytes, off;
        logic [63:0] a;
        for (int k = 0; k < 80; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            dbus_ena = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          sz = int'($urandom_range(0, 3));
          bytes = 1 << sz;
          off = bytes * int'($urandom_range(0, 8 / bytes - 1));
          a = 64'h1000_0000 + 64'(8 * $urandom_range(0, 15)) + 64'(off);
          if ($urandom_range(0, 2) == 0)
            dbus_issue(1'b1, a, 3'd0, 8'(((1 << bytes) - 1) << off), {$urandom, $urandom});
          else
            dbus_issue(1'b0, a, 3'(bytes - 1), 8'h00, 64'h0);
          dbus_wait(nd);
        end
        dbus_ena = 1'b0;
      end
      begin
        for (int k = 0; k < 80; k++) begin
          if ($urandom_range(0, 4) == 0) begin
            ibus_ena = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          ibus_issue(rand_iaddr());
          ibus_wait(5);
        end
        ibus_ena = 1'b0;
      end
    join

    repeat (5) @(negedge clk);
    chk("d_queue_empty", d_exp.size(), 0);
    chk("i_queue_empty", i_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
